sdram_slot_arbiter: RTL

Time-slot scheduler and arbiter in front of the 8-bit `sdram` controller core. It shares one core access port between three requesters: video/PPU, CPU, and SPI loader. It generates the core's `clkref` slot timing and issues at most one read or write per slot. It returns acks and read data to the winning requester. It runs in the `clk_sdram` domain.

---
 rtl/sdram_slot_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/sdram_slot_arbiter.sv
// sdram_slot_arbiter: slot scheduler sharing one SDRAM core port between
// video/PPU (0), CPU (1) and SPI loader (2). Each slot is SLOT_CYCLES clocks;
// the winner is chosen at the last cycle of a slot and its command is held
// for the whole next slot.
// Optional build macro: SDRAM_ARB_PRIO0_EN gives requester 0 absolute
// priority, with requesters 1 and 2 sharing a round-robin among themselves.
module sdram_slot_arbiter #(
  parameter int unsigned SLOT_CYCLES = 8,
  parameter int unsigned RD_CAPTURE  = 7,
  parameter int unsigned AW          = 25,
  parameter int unsigned DW          = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              init,
  input  logic [2:0]        req,
  input  logic [2:0]        we,
  input  logic [3*AW-1:0]   addr,
  input  logic [3*DW-1:0]   din,
  output logic [2:0]        ack,
  output logic [2:0]        rvalid,
  output logic [DW-1:0]     dout,
  output logic              busy,
  output logic              sd_clkref,
  output logic              sd_we,
  output logic              sd_oe,
  output logic [AW-1:0]     sd_addr,
  output logic [DW-1:0]     sd_din,
  input  logic [DW-1:0]     sd_dout
);

  localparam int unsigned CW = $clog2(SLOT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_CAP  = CW'(RD_CAPTURE);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    own_q, own_d;
  logic [2:0]    ack_q, ack_d;
  logic [2:0]    rvalid_q, rvalid_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          busy_q, busy_d;
  logic          clkref_q, clkref_d;
  logic          we_q, we_d;
  logic          oe_q, oe_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;

  logic          win_vld;
  logic [1:0]    win_idx;
  logic [1:0]    win_ptr;

  // Modulo-3 increment for the rotation pointer.
  function automatic logic [1:0] nxt3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Pick the winner among the live requests and the pointer value after it.
  always_comb begin
    win_vld = 1'b0;
    win_idx = 2'd0;
    win_ptr = ptr_q;
`ifdef SDRAM_ARB_PRIO0_EN
    if (req[0]) begin
      win_vld = 1'b1;
      win_idx = 2'd0;
    end else if (ptr_q[0] == 1'b0) begin
      if (req[1]) begin
        win_vld = 1'b1;
        win_idx = 2'd1;
      end else if (req[2]) begin
        win_vld = 1'b1;
        win_idx = 2'd2;
      end
    end else begin
      if (req[2]) begin
        win_vld = 1'b1;
        win_idx = 2'd2;
      end else if (req[1]) begin
        win_vld = 1'b1;
        win_idx = 2'd1;
      end
    end
    // 1-bit rotation between requesters 1 and 2, untouched by video grants.
    if (win_idx == 2'd1) win_ptr = 2'd1;
    else if (win_idx == 2'd2) win_ptr = 2'd0;
`else
    if (req[ptr_q]) begin
      win_vld = 1'b1;
      win_idx = ptr_q;
    end else if (req[nxt3(ptr_q)]) begin
      win_vld = 1'b1;
      win_idx = nxt3(ptr_q);
    end else if (req[nxt3(nxt3(ptr_q))]) begin
      win_vld = 1'b1;
      win_idx = nxt3(nxt3(ptr_q));
    end
    win_ptr = nxt3(win_idx);
`endif
  end

  // Next-state: slot timing, grant at slot boundary, read capture.
  always_comb begin
    cnt_d    = cnt_q + CW'(1);
    clkref_d = cnt_d[CW-1];
    ptr_d    = ptr_q;
    own_d    = own_q;
    ack_d    = 3'b000;
    rvalid_d = 3'b000;
    dout_d   = dout_q;
    busy_d   = busy_q;
    we_d     = we_q;
    oe_d     = oe_q;
    addr_d   = addr_q;
    din_d    = din_q;

    if (cnt_q == CNT_LAST) begin
      if (!init && win_vld) begin
        addr_d = addr[win_idx*AW +: AW];
        din_d  = din[win_idx*DW +: DW];
        we_d   = we[win_idx];
        oe_d   = ~we[win_idx];
        busy_d = 1'b1;
        ack_d  = 3'b001 << win_idx;
        ptr_d  = win_ptr;
        own_d  = win_idx;
      end else begin
        we_d   = 1'b0;
        oe_d   = 1'b0;
        busy_d = 1'b0;
      end
    end

    // Uses the current slot's command even when capture coincides with a boundary.
    if ((cnt_q == CNT_CAP) && oe_q) begin
      dout_d   = sd_dout;
      rvalid_d = 3'b001 << own_q;
    end
  end

  // State registers; reset abandons any slot in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      ptr_q    <= 2'd0;
      own_q    <= 2'd0;
      ack_q    <= 3'b000;
      rvalid_q <= 3'b000;
      dout_q   <= '0;
      busy_q   <= 1'b0;
      clkref_q <= 1'b0;
      we_q     <= 1'b0;
      oe_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      own_q    <= own_d;
      ack_q    <= ack_d;
      rvalid_q <= rvalid_d;
      dout_q   <= dout_d;
      busy_q   <= busy_d;
      clkref_q <= clkref_d;
      we_q     <= we_d;
      oe_q     <= oe_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
    end
  end

  assign ack       = ack_q;
  assign rvalid    = rvalid_q;
  assign dout      = dout_q;
  assign busy      = busy_q;
  assign sd_clkref = clkref_q;
  assign sd_we     = we_q;
  assign sd_oe     = oe_q;
  assign sd_addr   = addr_q;
  assign sd_din    = din_q;

endmodule
